// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
//
// Purpose:
//   Sequential packed-BCD to unsigned binary converter. A captured BCD word is
//   folded into a 32-bit accumulator one digit per clock, most significant
//   digit first, using acc = acc*10 + d (computed as (acc<<3)+(acc<<1)+d).
//   Any nibble above 9 contributes zero and raises digit_err. The block
//   takes one word at a time and holds its result until the consumer
//   accepts it.
//
// Parameters:
//   DIGITS     number of packed BCD digits (1..9; 9 digits always fit in 32 bits)
//
// Ports:
//   clk        system clock, rising edge active
//   rst_n      asynchronous active-low reset
//   abort      synchronous abandon of any conversion; beats in_valid/out_ready
//   in_valid   bcd_in is presented
//   in_ready   high only in IDLE; a word is captured when in_valid is also high
//   bcd_in     packed BCD, most significant digit in the top nibble
//   out_valid  high only in DONE; bin_out/digit_err are valid
//   out_ready  consumer accepts the result; DONE -> IDLE
//   bin_out    accumulator contents (meaningful only while out_valid is high)
//   digit_err  one or more captured nibbles were greater than 9
// -----------------------------------------------------------------------------
module bcd_to_bin #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           bin_out,
    output logic                  digit_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [4*DIGITS-1:0]   r_bcd;       // captured word, shifted left as digits are consumed
    logic [31:0]           r_acc;
    logic                  r_err;
    logic [3:0]            r_cnt;       // digits consumed so far in CONV
    logic                  r_in_ready;
    logic                  r_out_valid;

    logic [3:0]            w_nibble;
    logic                  w_bad;
    logic [3:0]            w_digit;
    logic [31:0]           w_acc_next;

    // Datapath for one CONV step: the next digit is always the top nibble of
    // the shifting capture register, so no digit index mux is needed.
    // NOTE: every signal assigned in always_comb is given a value on every
    // path, so no latch can be inferred.
    always_comb begin
        w_nibble   = r_bcd[4*DIGITS-1 -: 4];
        w_bad      = (w_nibble > 4'd9);
        w_digit    = w_bad ? 4'd0 : w_nibble;
        w_acc_next = (r_acc << 3) + (r_acc << 1) + {28'd0, w_digit};
    end

    // Single-process FSM. in_ready/out_valid are registered alongside the
    // state so they always match it, including during reset (IDLE => ready).
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bcd       <= '0;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (abort) begin
            // Abort wins over any handshake in the same cycle.
            r_state     <= IDLE;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bcd       <= bcd_in;
                        r_acc       <= '0;
                        r_err       <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= CONV;
                        r_in_ready  <= 1'b0;
                    end
                end

                CONV: begin
                    r_acc <= w_acc_next;
                    r_err <= r_err | w_bad;
                    r_bcd <= r_bcd << 4;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(DIGITS - 1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    // Returning to IDLE here means a new word can be taken no
                    // earlier than the following edge.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bin_out   = r_acc;
    assign digit_err = r_err;

endmodule
